alu_op_dispatch: RTL and testbench

- Issue-side controller for the ALU result register stage.
- Accepts an opcode and two 4-bit operands on a start strobe, latches them, and drives exactly one of the one-hot operation flags aCmp/aAdd/aSub/aDiv/aMul for the unit's latency.
- The result register stage captures the selected unit's result while that flag is high.
- Signals completion with a done pulse and rejects illegal opcodes with an err pulse.

---
 rtl/alu_op_dispatch_if.sv | 30 +++
 rtl/alu_op_dispatch.sv | 135 +++++++++++++
 tb/tb_alu_op_dispatch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_dispatch_if.sv
// Issue-side bus between the ALU dispatcher and its requester.
// The requester drives the strobe and operands. The dispatcher returns flags and status.
interface alu_op_dispatch_if;
  logic       start;
  logic [2:0] opcode;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] A;
  logic [3:0] B;
  logic       aCmp;
  logic       aAdd;
  logic       aSub;
  logic       aDiv;
  logic       aMul;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, opcode, a_in, b_in,
    input  A, B, aCmp, aAdd, aSub, aDiv, aMul,
    input  busy, done, err
  );

  modport slave (
    input  start, opcode, a_in, b_in,
    output A, B, aCmp, aAdd, aSub, aDiv, aMul,
    output busy, done, err
  );
endinterface

// File: rtl/alu_op_dispatch.sv
// ALU op dispatcher: latches an op and holds one one-hot unit flag for its latency.
// It then pulses done. Illegal opcodes seen in IDLE pulse err.
module alu_op_dispatch #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_dispatch_if.slave   bus
);

  localparam logic [3:0] ADD_M1 = 4'(ADD_LAT - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_LAT - 1);
  localparam logic [3:0] MUL_M1 = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [4:0] flg_q, flg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       legal;
  logic [3:0] lat_m1;
  logic [4:0] sel;

  // Flag bit order: cmp, add, sub, div, mul.
  always_comb begin
    legal  = 1'b1;
    lat_m1 = ADD_M1;
    sel    = 5'b00000;
    unique case (bus.opcode)
      3'd0: sel = 5'b00001;
      3'd1: sel = 5'b00010;
      3'd2: sel = 5'b00100;
      3'd3: begin
        sel    = 5'b01000;
        lat_m1 = DIV_M1;
      end
      3'd4: begin
        sel    = 5'b10000;
        lat_m1 = MUL_M1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    flg_d   = flg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_d = EXEC;
            cnt_d   = lat_m1;
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            flg_d   = sel;
            busy_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          flg_d   = 5'b00000;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        flg_d   = 5'b00000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      flg_q   <= 5'b00000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.aCmp = flg_q[0];
  assign bus.aAdd = flg_q[1];
  assign bus.aSub = flg_q[2];
  assign bus.aDiv = flg_q[3];
  assign bus.aMul = flg_q[4];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Bench for alu_op_dispatch: directed plan plus random traffic.
// A cycle-age reference model predicts every output.
module tb_alu_op_dispatch;

  localparam int ADD_LAT = 1;
  localparam int DIV_LAT = 4;
  localparam int MUL_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alu_op_dispatch_if bus ();

  alu_op_dispatch #(
    .ADD_LAT (ADD_LAT),
    .DIV_LAT (DIV_LAT),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: an accepted op is "active" for age 1..lat+1.
  bit         m_act;
  int         m_age;
  int         m_lat;
  int         m_op;
  logic [3:0] m_a;
  logic [3:0] m_b;
  bit         m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int lat_of(input int op);
    if (op == 3) return DIV_LAT;
    if (op == 4) return MUL_LAT;
    return ADD_LAT;
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_age = 0;
    m_lat = 0;
    m_op  = 0;
    m_a   = 4'd0;
    m_b   = 4'd0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] ef;
    logic [4:0] gf;
    bit         ed;
    ef = (m_act && m_age <= m_lat) ? 5'(1 << m_op) : 5'd0;
    ed = m_act && (m_age == m_lat + 1);
    gf = {bus.aMul, bus.aDiv, bus.aSub, bus.aAdd, bus.aCmp};
    chk({tag, ".flags"}, 32'(gf), 32'(ef));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_act));
    chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
    chk({tag, ".A"}, 32'(bus.A), 32'(m_a));
    chk({tag, ".B"}, 32'(bus.B), 32'(m_b));
  endtask

  // Advance the model with the inputs present before the edge, then compare.
  task automatic step(input string tag);
    m_err = 1'b0;
    if (m_act) begin
      if (m_age == m_lat + 1) m_act = 1'b0;
      else m_age++;
    end else if (bus.start) begin
      if (int'(bus.opcode) <= 4) begin
        m_act = 1'b1;
        m_age = 1;
        m_op  = int'(bus.opcode);
        m_lat = lat_of(m_op);
        m_a   = bus.a_in;
        m_b   = bus.b_in;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic s, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    bus.start  = s;
    bus.opcode = op;
    bus.a_in   = a;
    bus.b_in   = b;
  endtask

  initial begin
    int cnt;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    model_reset();

    // Reset asserted mid-cycle, then idle.
    #2 rst_n = 1'b0;
    #1 check_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle");

    // Add 3,5.
    drive(1'b1, 3'd1, 4'h3, 4'h5);
    step("add_issue");
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    step("add_done");
    chk("add_done_pulse", 32'(bus.done), 32'd1);
    step("add_idle");
    step("add_idle2");

    // Illegal opcode in IDLE.
    drive(1'b1, 3'd6, 4'hF, 4'hF);
    step("illegal");
    chk("illegal_err", 32'(bus.err), 32'd1);
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    step("illegal_after");

    // Div with a start pulse while busy.
    cnt = 0;
    drive(1'b1, 3'd3, 4'hC, 4'h3);
    step("div");
    cnt += int'(bus.aDiv);
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    step("div");
    cnt += int'(bus.aDiv);
    drive(1'b1, 3'd1, 4'h7, 4'h7);
    step("div_busy_start");
    cnt += int'(bus.aDiv);
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step("div");
      cnt += int'(bus.aDiv);
    end
    chk("div_flag_len", 32'(cnt), 32'(DIV_LAT));

    // Mul.
    cnt = 0;
    drive(1'b1, 3'd4, 4'h9, 4'h2);
    step("mul");
    cnt += int'(bus.aMul);
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step("mul");
      cnt += int'(bus.aMul);
    end
    chk("mul_flag_len", 32'(cnt), 32'(MUL_LAT));

    // Back-to-back: sub, then cmp held on start.
    drive(1'b1, 3'd2, 4'hA, 4'h1);
    step("b2b_sub");
    drive(1'b1, 3'd0, 4'h4, 4'h4);
    for (int i = 0; i < 3; i++) step("b2b_wait");
    chk("b2b_cmp_taken", 32'(bus.aCmp), 32'd1);
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step("b2b_tail");

    // Reset during the second aDiv cycle.
    drive(1'b1, 3'd3, 4'hE, 4'hD);
    step("rst_div");
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    step("rst_div");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("rst_after");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0),
            3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
